// File: rtl/des_sbox_engine.sv
// DES round substitution: S1..S8 lookup of a 48-bit word into 32 bits,
// evaluating LANES S-boxes per cycle behind valid/ready handshakes.
module des_sbox_engine #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int ITER = 8 / LANES;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // Each entry packs rows 0..3, 16 nibbles per row, row 0 column 0 in the MSBs.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [47:0]     hold;
    logic [31:0]     result;
    logic [2:0]      sel [LANES];
    logic [3:0]      nib [LANES];

    function automatic logic [3:0] lookup(input logic [2:0] s, input logic [5:0] b);
        logic [5:0] idx;
        idx = {b[5], b[0], b[4:1]};
        // Table position 255-4*idx, written as {~idx, 2'b11}.
        return SBOX[s][{~idx, 2'b11} -: 4];
    endfunction

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            sel[j] = 3'(int'(cnt) * LANES + j);
            nib[j] = lookup(sel[j], hold[6'(47 - 6 * int'(sel[j])) -: 6]);
        end
    end

    assign out_data = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold     <= in_data;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        result[{~sel[j], 2'b11} -: 4] <= nib[j];
                    end
                    if (cnt == CW'(ITER - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: one instance per legal LANES value,
// directed vector table, handshake corner cases and a random scoreboard run.
module tb_des_sbox_engine;

    localparam logic [63:0] ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv    [4];
    logic        ir    [4];
    logic        ov    [4];
    logic        ordy  [4];
    logic        bz    [4];
    logic [47:0] idata [4];
    logic [31:0] odata [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            des_sbox_engine #(.LANES(1 << g)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (iv[g]),
                .in_ready (ir[g]),
                .in_data  (idata[g]),
                .out_valid(ov[g]),
                .out_ready(ordy[g]),
                .out_data (odata[g]),
                .busy     (bz[g])
            );
        end
    endgenerate

    typedef struct {
        int          k;
        logic [47:0] din;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vec [10];

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  b;
        logic [63:0] w;
        int          row;
        int          col;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            b   = d[47 - 6 * s -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            w   = ROWS[s * 4 + row];
            r[31 - 4 * s -: 4] = w[63 - 4 * col -: 4];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_word(input int k, input logic [47:0] d,
                             output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!ir[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        iv[k]    = 1'b1;
        idata[k] = d;
        @(negedge clk);
        iv[k]    = 1'b0;
        idata[k] = ~d;
        lat = 0;
        while (!ov[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res     = odata[k];
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] q [$];
        int          sent;
        int          recv;
        int          cyc;
        logic        acc;
        logic        dlv;
        sent = 0;
        recv = 0;
        cyc  = 0;
        idata[k] = 48'({$urandom(), $urandom()});
        iv[k]    = 1'b1;
        ordy[k]  = 1'($urandom_range(0, 1));
        while (recv < n && cyc < 30000) begin
            acc = iv[k] && ir[k];
            dlv = ov[k] && ordy[k];
            if (dlv) begin
                if (q.size() == 0) begin
                    chk($sformatf("rand_stale_L%0d", 1 << k), 64'(odata[k]), 64'hDEAD);
                end else begin
                    chk($sformatf("rand_data_L%0d", 1 << k), 64'(odata[k]), 64'(q.pop_front()));
                end
                recv++;
            end
            if (acc) q.push_back(model(idata[k]));
            @(negedge clk);
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) idata[k] = 48'({$urandom(), $urandom()});
                else iv[k] = 1'b0;
            end
            ordy[k] = 1'($urandom_range(0, 1));
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b0;
        chk($sformatf("rand_count_L%0d", 1 << k), 64'(recv), 64'(n));
        chk($sformatf("rand_left_L%0d", 1 << k), 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        stale;

        vec[0] = '{0, 48'h0, 32'hEFA72C4D, 8};
        vec[1] = '{1, 48'h0, 32'hEFA72C4D, 4};
        vec[2] = '{3, 48'h0, 32'hEFA72C4D, 1};
        vec[3] = '{2, 48'h0, 32'hEFA72C4D, 2};
        vec[4] = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 8};
        vec[5] = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 4};
        vec[6] = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 2};
        vec[7] = '{3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 1};
        vec[8] = '{1, 48'h000180000000, 32'hEFE72C4D, 4};
        vec[9] = '{1, 48'h0009C0000000, 32'hEF072C4D, 4};

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k]    = 1'b0;
            ordy[k]  = 1'b0;
            idata[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_ready_L%0d", 1 << k), 64'(ir[k]), 64'd1);
            chk($sformatf("reset_valid_L%0d", 1 << k), 64'(ov[k]), 64'd0);
            chk($sformatf("reset_busy_L%0d", 1 << k), 64'(bz[k]), 64'd0);
            chk($sformatf("reset_data_L%0d", 1 << k), 64'(odata[k]), 64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            send_word(vec[i].k, vec[i].din, res, lat);
            chk($sformatf("vec%0d_data", i), 64'(res), 64'(vec[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vec[i].lat));
        end

        // Backpressure on LANES=2: a word offered in DONE must be ignored.
        iv[1]    = 1'b1;
        idata[1] = 48'h0;
        @(negedge clk);
        iv[1] = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_data", 64'(odata[1]), 64'hEFA72C4D);
            chk("bp_hold_ready", 64'(ir[1]), 64'd0);
            chk("bp_hold_valid", 64'(ov[1]), 64'd1);
            iv[1]    = 1'b1;
            idata[1] = 48'hFFFFFFFFFFFF;
            @(negedge clk);
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        chk("bp_drain_ready", 64'(ir[1]), 64'd1);
        chk("bp_drain_valid", 64'(ov[1]), 64'd0);
        idata[1] = 48'h000180000000;
        @(negedge clk);
        iv[1] = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_data", 64'(odata[1]), 64'hEFE72C4D);
        chk("bp_next_latency", 64'(lat), 64'd4);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;

        // Reset three cycles into a LANES=1 word.
        iv[0]    = 1'b1;
        idata[0] = 48'hFFFFFFFFFFFF;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 64'(bz[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_busy", 64'(bz[0]), 64'd0);
        chk("midrst_data", 64'(odata[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(ir[0]), 64'd1);
        ordy[0] = 1'b1;
        stale = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov[0] || odata[0] != 32'h0) stale = 1'b1;
        end
        ordy[0] = 1'b0;
        chk("midrst_no_stale", 64'(stale), 64'd0);

        for (int k = 0; k < 4; k++) random_run(k, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/des_sbox_engine.md
Name: des_sbox_engine

Overview:
- Parametrised DES substitution stage: takes the 48-bit post-key-mix word of one round and returns the 32-bit S-box output (S1..S8), before the P permutation.
- Generalises the single-S-box combinational lookups into one sequential unit with a configurable number of S-box lanes.
- Each lane evaluates one S-box per cycle, so area trades against latency.
- Sits between the key-XOR and P-permutation stages of the round datapath, with valid/ready handshakes on both sides.

Parameters:
- LANES, 2, number of S-boxes evaluated per cycle. Legal values 1, 2, 4, 8; any other value is an elaboration error.
- ITER, 8/LANES (derived localparam, not overridable), number of BUSY cycles per word.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  48  S1 chunk at [47:42], S2 at [41:36], ..., S8 at [5:0]
- out_valid  output  1  out_data holds a complete result
- out_ready  input  1  downstream accepts the result
- out_data  output  32  S1 nibble at [31:28], ..., S8 nibble at [3:0]
- busy  output  1  high in BUSY state

Behaviour:
- S-box decode, for each 6-bit chunk b[5:0]:
  - row = {b5,b0}, column = b[4:1].
  - The value is the FIPS 46-3 table entry for that S-box.
  - All 64 entries of all 8 tables are defined; there is no default/X output.
- Lanes: LANES instances of an 8-way selectable table (one per lane). Lane j in iteration i handles S-box i*LANES+j+1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid is high, latch in_data into a 48-bit holding register, clear the iteration counter to 0, and go to BUSY.
  - BUSY: each cycle, write LANES result nibbles into the 32-bit result register at the positions of the current iteration, then increment the counter. On the cycle the counter equals ITER-1, write and go to DONE.
  - DONE: out_valid=1. out_data is stable and unchanged while out_ready=0. When out_ready is high, go to IDLE.
- Handshake rules:
  - in_ready is high only in IDLE, so no word is accepted in DONE, even on the cycle it is drained.
  - in_data may change freely after the accepting edge.
- Latency: out_valid rises exactly ITER cycles after the accepting edge (LANES=8 gives 1 cycle; LANES=1 gives 8 cycles).
- Throughput: one word per ITER+2 cycles when out_ready is held high.
- Counter width is clog2(ITER), minimum 1 bit. The counter never wraps past ITER-1.
- Reset (asynchronous assert, any state, including mid-BUSY):
  - state goes to IDLE, counter 0, holding and result registers 0.
  - out_valid=0, busy=0, out_data=0.
  - in_ready=1 once rst_n is deasserted.
  - A partially processed word is discarded and never emitted.
- out_data is always driven from the result register and is 0 after reset. In BUSY, partially written nibbles are visible, but out_valid=0.

Test Plan:
- Reset mid-word: LANES=1, accept a word, assert rst_n=0 after 3 BUSY cycles → immediately out_valid=0, busy=0, out_data=0; after release in_ready=1 and no stale output ever appears.
- All-zero input, in_data=48'h0 → out_data=32'hEFA72C4D. Check with LANES=1 (out_valid at cycle 8), LANES=2 (cycle 4), LANES=8 (cycle 1).
- All-ones input, in_data=48'hFFFFFFFFFFFF → out_data=32'hD9CE3DCB for every legal LANES value.
- S3 row/column decode: set the S3 chunk to 6'b000110 and all other chunks to 0 → nibble [23:20]=14. Then set the S3 chunk to 6'b100111 → nibble=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0, a new in_valid is ignored. Raise out_ready → one cycle later in_ready=1 and the next word is accepted.
- Randomised: 1000 random words per LANES value against a software DES S-box model. Back-to-back in_valid and random out_ready must produce no dropped or duplicated results.
